// File: rtl/adc_pkg.sv
// adc_pkg: shared types and frame constants for the dual-channel ADC
// serial capture front-end (adc_handshake and its serial-clock generator).
//
// Contents:
//   state_t    - capture FSM state (IDLE / CONVERT / QUIET), 2 bits
//   FRAME_BITS - serial bits per frame (4 leading zeros + 12 data bits)
//   DATA_BITS  - sample width delivered on data_out1/data_out2
//   LEAD_BITS  - leading bits that must read zero in a good frame
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        QUIET   = 2'd2
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int LEAD_BITS  = 4;

endpackage

// File: rtl/adc_sclk_gen.sv
// adc_sclk_gen: serial clock generator for the ADC capture front-end.
// Owns the SCLK_DIV divider and the adc_clk flop.  adc_clk idles high,
// drops low on start, and toggles every SCLK_DIV clk cycles while active.
//
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-low reset
//   start     in  frame accepted this cycle: adc_clk goes low next cycle
//   active    in  FSM is in CONVERT
//   stop      in  last high phase ends this cycle: park adc_clk high
//   adc_clk   out registered serial clock to the ADC
//   rise      out adc_clk goes 0->1 at the coming clk edge (shift strobe)
//   phase_end out current adc_clk half-period ends at the coming clk edge
module adc_sclk_gen #(
    parameter int SCLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    input  logic stop,
    output logic adc_clk,
    output logic rise,
    output logic phase_end
);

    localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    logic [CW-1:0] div_cnt;

    assign phase_end = active && (div_cnt == CW'(SCLK_DIV - 1));
    // Strobe lines up with the clk edge that makes adc_clk high, so the
    // shift registers sample at the same instant the ADC sees its edge.
    assign rise      = phase_end && !adc_clk;

    always_ff @(posedge clk) begin
        if (!rst) begin
            adc_clk <= 1'b1;
            div_cnt <= '0;
        end else if (start) begin
            adc_clk <= 1'b0;
            div_cnt <= '0;
        end else if (stop || !active) begin
            adc_clk <= 1'b1;
            div_cnt <= '0;
        end else if (phase_end) begin
            adc_clk <= ~adc_clk;
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adc_handshake.sv
// adc_handshake: serial capture front-end for the dual-channel 12-bit ADC.
// On go it runs one 16-bit frame (chip select low, adc_clk bursts), shifts
// in both serial data lines MSB first, then presents the 12-bit samples
// with a one-cycle valid pulse and holds chip select high for a quiet gap.
//
// Optional feature macro: ADC_LEADING_ZERO_CHECK_EN.  When defined,
// frame_err is refreshed on each valid cycle (1 if either channel's four
// leading bits are nonzero) and holds between frames.  When undefined,
// frame_err is tied to 0.
//
// Handshake: go is acted on only in a cycle where ready=1; go while
// ready=0 is dropped, never queued.  valid is a single-cycle pulse with no
// back-pressure; data_out1/data_out2 change only in a valid cycle.
//
// Ports:
//   clk        in  system clock
//   rst        in  synchronous active-low reset
//   go         in  start a frame (sampled while ready=1)
//   data_in1   in  serial data, ADC channel 1
//   data_in2   in  serial data, ADC channel 2
//   adc_clk    out serial clock to ADC, idles high (flop output)
//   chip_sel   out ADC chip select, active low
//   data_out1  out last captured channel-1 sample
//   data_out2  out last captured channel-2 sample
//   valid      out one-cycle pulse when data_out1/data_out2 update
//   ready      out idle, will accept go
//   frame_err  out leading-bit error flag
//   fsm_state  out current FSM state (debug observation)
import adc_pkg::*;

module adc_handshake #(
    parameter int SCLK_DIV     = 1,
    parameter int QUIET_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 data_in1,
    input  logic                 data_in2,
    output logic                 adc_clk,
    output logic                 chip_sel,
    output logic [DATA_BITS-1:0] data_out1,
    output logic [DATA_BITS-1:0] data_out2,
    output logic                 valid,
    output logic                 ready,
    output logic                 frame_err,
    output state_t               fsm_state
);

    localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

    state_t                state;
    logic [4:0]            bit_cnt;
    logic [QW-1:0]         quiet_cnt;
    logic [FRAME_BITS-1:0] shift1;
    logic [FRAME_BITS-1:0] shift2;

    logic start;
    logic active;
    logic rise;
    logic phase_end;
    logic frame_done;

    assign fsm_state = state;
    assign start     = (state == IDLE) && go;
    assign active    = (state == CONVERT);
    // The frame ends when the 16th high phase of adc_clk runs out.
    assign frame_done = phase_end && adc_clk && (bit_cnt == 5'(FRAME_BITS));

    adc_sclk_gen #(
        .SCLK_DIV(SCLK_DIV)
    ) u_sclk (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .active   (active),
        .stop     (frame_done),
        .adc_clk  (adc_clk),
        .rise     (rise),
        .phase_end(phase_end)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            chip_sel  <= 1'b1;
            valid     <= 1'b0;
            ready     <= 1'b1;
            data_out1 <= '0;
            data_out2 <= '0;
            bit_cnt   <= '0;
            quiet_cnt <= '0;
            shift1    <= '0;
            shift2    <= '0;
`ifdef ADC_LEADING_ZERO_CHECK_EN
            frame_err <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        state    <= CONVERT;
                        chip_sel <= 1'b0;
                        ready    <= 1'b0;
                        bit_cnt  <= '0;
                        shift1   <= '0;
                        shift2   <= '0;
                    end
                end
                CONVERT: begin
                    if (rise) begin
                        shift1  <= {shift1[FRAME_BITS-2:0], data_in1};
                        shift2  <= {shift2[FRAME_BITS-2:0], data_in2};
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                    if (frame_done) begin
                        state     <= QUIET;
                        chip_sel  <= 1'b1;
                        valid     <= 1'b1;
                        quiet_cnt <= '0;
                        data_out1 <= shift1[DATA_BITS-1:0];
                        data_out2 <= shift2[DATA_BITS-1:0];
`ifdef ADC_LEADING_ZERO_CHECK_EN
                        frame_err <= (|shift1[FRAME_BITS-1:DATA_BITS]) |
                                     (|shift2[FRAME_BITS-1:DATA_BITS]);
`endif
                    end
                end
                QUIET: begin
                    // The valid cycle is the first of the QUIET_CYCLES gap.
                    if (quiet_cnt == QW'(QUIET_CYCLES - 1)) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        quiet_cnt <= quiet_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    chip_sel <= 1'b1;
                    ready    <= 1'b1;
                end
            endcase
        end
    end

`ifndef ADC_LEADING_ZERO_CHECK_EN
    // Leading bits are shifted in but not inspected in this build.
    logic unused_lead;
    assign unused_lead = ^{shift1[FRAME_BITS-1:DATA_BITS], shift2[FRAME_BITS-1:DATA_BITS]};
    assign frame_err   = 1'b0;
`endif

endmodule
